// File: rtl/pingpong_buf_ctrl.sv
// rtl/pingpong_buf_ctrl.sv - ping-pong capture buffer sequencer with consumer handshake and overrun counting
module pingpong_buf_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11,
  parameter logic [DATA_WIDTH-1:0] DC_OFFSET = 16'h7FFF
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  EN,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ping_we,
  output logic                  pong_we,
  output logic                  buf_ready,
  output logic                  buf_sel,
  input  logic                  buf_ack,
  output logic                  overrun,
  input  logic                  ovr_clr,
  output logic [15:0]           drop_count
);

  typedef enum logic {S_IDLE, S_CAPTURE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic [1:0]            r_full;
  logic                  r_set_pend;
  logic                  r_set_bank;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_data;
  logic                  r_ping_we;
  logic                  r_pong_we;
  logic                  r_overrun;
  logic [15:0]           r_drop_count;

  logic                  w_ack;
  logic [1:0]            w_clr;
  logic [1:0]            w_set;
  logic [1:0]            w_full_eff;
  logic                  w_cap;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_last;

  always_ff @(posedge HCLK) begin
    if (HRESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (EN)  w_state_nxt = S_CAPTURE;
      S_CAPTURE: if (!EN) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // An ack frees its bank before the overrun decision, so a sample arriving with it is kept.
  assign w_ack      = buf_ack & r_full[r_rd_bank];
  assign w_clr      = {w_ack & r_rd_bank, w_ack & ~r_rd_bank};
  assign w_set      = {r_set_pend & r_set_bank, r_set_pend & ~r_set_bank};
  assign w_full_eff = r_full & ~w_clr;
  assign w_cap      = (r_state == S_CAPTURE) & EN & sample_valid;
  assign w_drop     = w_cap & w_full_eff[r_wr_bank];
  assign w_accept   = w_cap & ~w_full_eff[r_wr_bank];
  assign w_last     = &r_wr_addr;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_wr_addr    <= '0;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_full       <= 2'b00;
      r_set_pend   <= 1'b0;
      r_set_bank   <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_data   <= '0;
      r_ping_we    <= 1'b0;
      r_pong_we    <= 1'b0;
      r_overrun    <= 1'b0;
      r_drop_count <= 16'h0000;
    end else begin
      r_ping_we <= w_accept & ~r_wr_bank;
      r_pong_we <= w_accept & r_wr_bank;
      if (w_accept) begin
        r_ram_addr <= r_wr_addr;
        r_ram_data <= sample_data - DC_OFFSET;
      end

      // Full flag lags the final write by a cycle so the consumer never sees a bank mid-write.
      r_set_pend <= w_accept & w_last;
      if (w_accept & w_last) r_set_bank <= r_wr_bank;
      r_full <= w_full_eff | w_set;
      if (w_ack) r_rd_bank <= ~r_rd_bank;

      if (!EN) begin
        r_wr_addr <= '0;
      end else if (w_accept) begin
        r_wr_addr <= r_wr_addr + 1'b1;
        if (w_last) r_wr_bank <= ~r_wr_bank;
      end

      if (ovr_clr) begin
        r_overrun    <= w_drop;
        r_drop_count <= w_drop ? 16'h0001 : 16'h0000;
      end else if (w_drop) begin
        r_overrun <= 1'b1;
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'h0001;
      end
    end
  end

  assign ram_addr   = r_ram_addr;
  assign ram_data   = r_ram_data;
  assign ping_we    = r_ping_we;
  assign pong_we    = r_pong_we;
  assign buf_ready  = r_full[r_rd_bank];
  assign buf_sel    = r_rd_bank;
  assign overrun    = r_overrun;
  assign drop_count = r_drop_count;

endmodule
